seg_scan_mux: RTL

Parametrised, time-multiplexed digit scanner for the multi-digit hex seven-segment display. It replaces the fixed 8-to-1 nibble mux and its externally driven select counter. The block owns the refresh prescaler and digit counter, double-buffers the display word so updates never tear mid-frame, and adds per-digit blanking, decimal points and leading-zero suppression. It sits between the datapath that produces the display value and the hex-to-segment decoder.

---
 rtl/seg_pkg.sv | 18 +
 rtl/seg_scan_mux_if.sv | 33 +++
 rtl/seg_scan_mux_tick_gen.sv | 29 ++
 rtl/seg_scan_mux.sv | 133 +++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment display blocks.
package seg_pkg;

  localparam int DIGIT_W = 4;

  // Anode polarity selectors: value of AN_ACTIVE_LOW for each wiring style.
  localparam bit AN_POL_LOW  = 1'b1;
  localparam bit AN_POL_HIGH = 1'b0;

  // Width needed to hold values 0..n-1; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Display-word input and scan output bundle between the datapath and the digit scanner.
interface seg_scan_mux_if
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8
) ();

  localparam int IDX_W = clog2(NUM_DIGITS);

  logic [DIGIT_W*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]         dp_in;
  logic [NUM_DIGITS-1:0]         blank_in;
  logic                          lzs_en;
  logic                          load;

  logic [NUM_DIGITS-1:0]         an;
  logic [DIGIT_W-1:0]            hex;
  logic                          dp;
  logic [IDX_W-1:0]              digit_idx;
  logic                          frame_done;
  logic                          pending;

  modport master (
    output data, dp_in, blank_in, lzs_en, load,
    input  an, hex, dp, digit_idx, frame_done, pending
  );

  modport slave (
    input  data, dp_in, blank_in, lzs_en, load,
    output an, hex, dp, digit_idx, frame_done, pending
  );

endinterface

// File: rtl/seg_scan_mux_tick_gen.sv
// Free-running prescaler: tick is high for one clock every DIV clocks.
module tick_gen
  import seg_pkg::*;
#(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int         W    = clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] pre;

  always_ff @(posedge clk) begin
    if (reset) begin
      pre <= '0;
    end else if (pre == LAST) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  assign tick = (pre == LAST);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed hex digit scanner with a double-buffered display word,
// per-digit blanking, decimal points and leading-zero suppression.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int REFRESH_DIV   = 100000,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  seg_scan_mux_if.slave  bus
);

  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE  =
    (AN_ACTIVE_LOW == AN_POL_LOW) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic tick;
  logic frameWrap;
  logic [IDX_W-1:0] idx;

  tick_gen #(
    .DIV (REFRESH_DIV)
  ) uTickGen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign frameWrap = tick && (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (tick) begin
      idx <= frameWrap ? '0 : idx + 1'b1;
    end
  end

  // Pending and active copies of the display word and its per-digit flags.
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] pendData;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] actData;
  logic [NUM_DIGITS-1:0]              pendDp;
  logic [NUM_DIGITS-1:0]              pendBlank;
  logic [NUM_DIGITS-1:0]              actDp;
  logic [NUM_DIGITS-1:0]              actBlank;
  logic                               pendingFlag;

  always_ff @(posedge clk) begin
    if (reset) begin
      pendData    <= '0;
      pendDp      <= '0;
      pendBlank   <= '0;
      actData     <= '0;
      actDp       <= '0;
      actBlank    <= '0;
      pendingFlag <= 1'b0;
    end else if (bus.load && frameWrap) begin
      // A load landing on the wrap goes straight to the active copy.
      actData     <= bus.data;
      actDp       <= bus.dp_in;
      actBlank    <= bus.blank_in;
      pendingFlag <= 1'b0;
    end else if (bus.load) begin
      pendData    <= bus.data;
      pendDp      <= bus.dp_in;
      pendBlank   <= bus.blank_in;
      pendingFlag <= 1'b1;
    end else if (frameWrap && pendingFlag) begin
      actData     <= pendData;
      actDp       <= pendDp;
      actBlank    <= pendBlank;
      pendingFlag <= 1'b0;
    end
  end

  // Digit k is suppressed when it and every digit to its left are zero.
  logic [NUM_DIGITS-1:0] suppress;
  logic [NUM_DIGITS-1:0] dark;

  assign suppress[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : gLzs
    assign suppress[gi] = bus.lzs_en && (actData[NUM_DIGITS-1:gi] == '0);
  end

  assign dark = actBlank | suppress;

  logic [NUM_DIGITS-1:0] anAssert;
  logic [NUM_DIGITS-1:0] anNext;
  logic [DIGIT_W-1:0]    hexNext;
  logic                  dpNext;

  always_comb begin
    anAssert = '0;
    hexNext  = '0;
    dpNext   = 1'b0;
    if (!dark[idx]) begin
      anAssert[idx] = 1'b1;
      hexNext       = actData[idx];
      dpNext        = actDp[idx];
    end
    anNext = (AN_ACTIVE_LOW == AN_POL_LOW) ? ~anAssert : anAssert;
  end

  logic [NUM_DIGITS-1:0] anReg;
  logic [DIGIT_W-1:0]    hexReg;
  logic                  dpReg;
  logic                  frameDoneReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      anReg        <= AN_IDLE;
      hexReg       <= '0;
      dpReg        <= 1'b0;
      frameDoneReg <= 1'b0;
    end else begin
      anReg        <= anNext;
      hexReg       <= hexNext;
      dpReg        <= dpNext;
      frameDoneReg <= frameWrap;
    end
  end

  assign bus.an         = anReg;
  assign bus.hex        = hexReg;
  assign bus.dp         = dpReg;
  assign bus.digit_idx  = idx;
  assign bus.frame_done = frameDoneReg;
  assign bus.pending    = pendingFlag;

endmodule
